load_store_unit: RTL and testbench

//  Sits between the execute stage and the word-addressed data memory (EN/RW/ADDr/Din/Dout).

---
 rtl/load_store_unit_if.sv | 31 +++
 rtl/load_store_unit.sv | 203 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response handshake plus data-memory port of the
// load/store unit. The slave modport is the unit itself; the master modport is
// its environment (execute stage on the request side, memory on the mem side).
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        mem_en;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
    output req_ready, rsp_valid, rsp_data, rsp_err,
           mem_en, mem_rw, mem_addr, mem_din
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
           mem_en, mem_rw, mem_addr, mem_din
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: turns RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into word
// accesses on a word-addressed data memory. Sub-word stores are done as
// read-modify-write; misaligned or illegal requests answer with rsp_err and
// touch no memory. One request is in flight at a time.
// Optional feature macro: LSU_RANGE_CHECK_EN (reject word index >= MEM_WORDS).
module load_store_unit #(
  parameter int MEM_WORDS = 21
) (
  input logic              CLK,
  input logic              RST_N,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RSP} state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

`ifdef LSU_RANGE_CHECK_EN
  localparam logic [29:0] MemWordsIdx = 30'(MEM_WORDS);
`endif

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_din_q, mem_din_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        accept;
  logic        req_err;

  // Pick the addressed byte/halfword out of a memory word and extend it.
  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    extract_load = {{24{b[7]}}, b};
      F3_H:    extract_load = {{16{h[15]}}, h};
      F3_BU:   extract_load = {24'h0, b};
      F3_HU:   extract_load = {16'h0, h};
      default: extract_load = word;
    endcase
  endfunction

  // Overlay the store byte/halfword on the word read back from memory.
  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane,
                                              input logic [15:0] wdata);
    logic [31:0] r;
    r = word;
    if (f3 == F3_B) begin
      r[{lane, 3'b000} +: 8] = wdata[7:0];
    end else if (lane[1]) begin
      r[31:16] = wdata;
    end else begin
      r[15:0] = wdata;
    end
    merge_store = r;
  endfunction

  assign accept = bus.req_valid && (state_q == IDLE);

  // Classify the presented request as legal or erroneous.
  always_comb begin
    req_err = 1'b0;
    case (bus.req_funct3)
      F3_B:    req_err = 1'b0;
      F3_H:    req_err = bus.req_addr[0];
      F3_W:    req_err = |bus.req_addr[1:0];
      F3_BU:   req_err = bus.req_we;
      F3_HU:   req_err = bus.req_we | bus.req_addr[0];
      default: req_err = 1'b1;
    endcase
`ifdef LSU_RANGE_CHECK_EN
    if (bus.req_addr[31:2] >= MemWordsIdx) begin
      req_err = 1'b1;
    end
`endif
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: errors answer at once, SW writes directly, loads and
  // sub-word stores read first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_d = RSP;
          end else if (bus.req_we && (bus.req_funct3 == F3_W)) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD:      state_d = CAP;
      CAP:     state_d = we_q ? WR : RSP;
      WR:      state_d = RSP;
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and memory strobes decoded from the current state.
  always_comb begin
    bus.req_ready = (state_q == IDLE) && RST_N;
    bus.rsp_valid = (state_q == RSP);
    bus.mem_en    = (state_q == RD) || (state_q == WR);
    bus.mem_rw    = (state_q == WR);
  end

  // Datapath next values: latch the request on accept, capture or merge the
  // read word in CAP, and settle the response before entering RSP.
  always_comb begin
    we_d       = we_q;
    funct3_d   = funct3_q;
    lane_d     = lane_q;
    wdata_d    = wdata_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    if (accept) begin
      we_d       = bus.req_we;
      funct3_d   = bus.req_funct3;
      lane_d     = bus.req_addr[1:0];
      wdata_d    = bus.req_wdata[15:0];
      mem_addr_d = {2'b00, bus.req_addr[31:2]};
      if (req_err) begin
        rsp_data_d = 32'h0;
        rsp_err_d  = 1'b1;
      end else if (bus.req_we && (bus.req_funct3 == F3_W)) begin
        mem_din_d = bus.req_wdata;
      end
    end
    case (state_q)
      CAP: begin
        if (we_q) begin
          mem_din_d = merge_store(bus.mem_dout, funct3_q, lane_q, wdata_q);
        end else begin
          rsp_data_d = extract_load(bus.mem_dout, funct3_q, lane_q);
          rsp_err_d  = 1'b0;
        end
      end
      WR: begin
        rsp_data_d = 32'h0;
        rsp_err_d  = 1'b0;
      end
      default: begin
      end
    endcase
  end

  // Datapath registers, cleared by reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      lane_q     <= 2'b00;
      wdata_q    <= 16'h0;
      mem_addr_q <= 32'h0;
      mem_din_q  <= 32'h0;
      rsp_data_q <= 32'h0;
      rsp_err_q  <= 1'b0;
    end else begin
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      lane_q     <= lane_d;
      wdata_q    <= wdata_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit
// against a word-array reference model with arithmetic extract/merge rules.
module tb_load_store_unit;
  localparam int MEM_WORDS = 21;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int assertions_evaluated = 0;
  int failures = 0;

  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  logic [31:0] mem_dout_r;
  assign bus.mem_dout = mem_dout_r;

  // Synchronous data memory: Dout registered on a read, zero otherwise.
  always @(posedge CLK) begin
    if (bus.mem_en && bus.mem_rw) mem[bus.mem_addr[4:0]] <= bus.mem_din;
    if (bus.mem_en && !bus.mem_rw) mem_dout_r <= mem[bus.mem_addr[4:0]];
    else mem_dout_r <= 32'h0;
  end

  int en_cycles, wr_cycles, rsp_pulses;
  logic [31:0] last_wr_addr, last_wr_din, last_rd_addr;

  // Bus observer sampled mid-cycle.
  always @(negedge CLK) begin
    if (bus.mem_en === 1'b1) en_cycles++;
    if (bus.mem_en === 1'b1 && bus.mem_rw === 1'b1) begin
      wr_cycles++;
      last_wr_addr = bus.mem_addr;
      last_wr_din = bus.mem_din;
    end
    if (bus.mem_en === 1'b1 && bus.mem_rw === 1'b0) last_rd_addr = bus.mem_addr;
    if (bus.rsp_valid === 1'b1) rsp_pulses++;
  end

  task automatic clear_monitor();
    en_cycles = 0;
    wr_cycles = 0;
    rsp_pulses = 0;
    last_wr_addr = 32'hFFFFFFFF;
    last_wr_din = 32'hFFFFFFFF;
    last_rd_addr = 32'hFFFFFFFF;
  endtask

  function automatic bit ref_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    int unsigned off;
    off = addr % 4;
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    if (we && (f3 == 4 || f3 == 5)) return 1'b1;
    if ((f3 == 1 || f3 == 5) && (off % 2) != 0) return 1'b1;
    if (f3 == 2 && off != 0) return 1'b1;
`ifdef LSU_RANGE_CHECK_EN
    if ((addr / 4) >= MEM_WORDS) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3, input logic [31:0] addr);
    int unsigned off;
    logic [31:0] b, h;
    off = addr % 4;
    b = (word >> (8 * off)) & 32'hFF;
    h = (word >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? (b | 32'hFFFFFF00) : b;
      3'b001:  return (h >= 32768) ? (h | 32'hFFFF0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] word, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    int unsigned off;
    logic [31:0] mask;
    off = addr % 4;
    if (f3 == 0) begin
      mask = 32'hFF << (8 * off);
      return (word & ~mask) | ((wd & 32'hFF) << (8 * off));
    end
    if (f3 == 1) begin
      mask = 32'hFFFF << (16 * (off / 2));
      return (word & ~mask) | ((wd & 32'hFFFF) << (16 * (off / 2)));
    end
    return wd;
  endfunction

  function automatic int ref_latency(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    if (ref_err(we, f3, addr)) return 1;
    if (we && f3 == 2) return 2;
    if (!we) return 3;
    return 4;
  endfunction

  // Drive one request, wait for its response, and report what was seen.
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                      output int lat, output logic [31:0] data, output logic err,
                      output logic after_valid, output logic [31:0] held_data);
    int guard;
    @(negedge CLK);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_funct3 = f3;
    bus.req_addr = addr;
    bus.req_wdata = wd;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    @(posedge CLK);
    #1;
    clear_monitor();
    bus.req_valid = 1'b0;
    bus.req_we = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr = $urandom;
    bus.req_wdata = $urandom;
    lat = -1;
    data = 32'hx;
    err = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      if (bus.rsp_valid === 1'b1) begin
        lat = c;
        data = bus.rsp_data;
        err = bus.rsp_err;
        break;
      end
    end
    @(negedge CLK);
    after_valid = bus.rsp_valid;
    held_data = bus.rsp_data;
  endtask

  task automatic fill_memory();
    int lat;
    logic [31:0] d, hd, v;
    logic e, av;
    int top;
`ifdef LSU_RANGE_CHECK_EN
    top = MEM_WORDS - 1;
`else
    top = MEM_WORDS;
`endif
    for (int i = 0; i <= top; i++) begin
      v = $urandom;
      send(1'b1, 3'b010, 32'(i * 4), v, lat, d, e, av, hd);
      ref_mem[i] = v;
    end
  endtask

  task automatic test_reset();
    int lat;
    logic [31:0] d, hd;
    logic e, av;
    #1;
    assertions_evaluated++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_en, bus.mem_rw} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got ready/valid/err/en/rw=%b expected 00000",
               {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_en, bus.mem_rw});
    end
    assertions_evaluated++;
    if ({bus.rsp_data, bus.mem_addr, bus.mem_din} !== 96'h0) begin
      failures++;
      $display("[TB] FAIL reset_data: got rsp_data=%h mem_addr=%h mem_din=%h expected 0",
               bus.rsp_data, bus.mem_addr, bus.mem_din);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    assertions_evaluated++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_release_ready: got %b expected 1", bus.req_ready);
    end
    fill_memory();
    send(1'b1, 3'b010, 32'h10, 32'hCAFEF00D, lat, d, e, av, hd);
    ref_mem[4] = 32'hCAFEF00D;
    send(1'b0, 3'b010, 32'h10, 32'h0, lat, d, e, av, hd);
    // Start an SB to word 3 and reset it while in the capture cycle.
    @(negedge CLK);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr = 32'hD;
    bus.req_wdata = 32'hA5;
    @(posedge CLK);
    #1;
    clear_monitor();
    bus.req_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    assertions_evaluated++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_en, bus.mem_rw} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL abort_ctrl: got ready/valid/err/en/rw=%b expected 00000",
               {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_en, bus.mem_rw});
    end
    assertions_evaluated++;
    if ({bus.rsp_data, bus.mem_addr, bus.mem_din} !== 96'h0) begin
      failures++;
      $display("[TB] FAIL abort_data: got rsp_data=%h mem_addr=%h mem_din=%h expected 0",
               bus.rsp_data, bus.mem_addr, bus.mem_din);
    end
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    #1;
    assertions_evaluated++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL abort_release_ready: got %b expected 1", bus.req_ready);
    end
    repeat (4) @(negedge CLK);
    assertions_evaluated++;
    if (wr_cycles !== 0 || rsp_pulses !== 0) begin
      failures++;
      $display("[TB] FAIL abort_no_activity: got writes=%0d responses=%0d expected 0 and 0", wr_cycles, rsp_pulses);
    end
    assertions_evaluated++;
    if (mem[3] !== ref_mem[3]) begin
      failures++;
      $display("[TB] FAIL abort_mem_untouched: got %h expected %h", mem[3], ref_mem[3]);
    end
  endtask

  task automatic test_directed();
    int lat;
    logic [31:0] d, hd;
    logic e, av;
    logic [2:0] f3s [4];
    logic [31:0] addrs [4];
    logic [31:0] exps [4];
    send(1'b1, 3'b010, 32'h8, 32'hDEADBEEF, lat, d, e, av, hd);
    ref_mem[2] = 32'hDEADBEEF;
    assertions_evaluated++;
    if (lat !== 2 || e !== 1'b0 || d !== 32'h0) begin
      failures++;
      $display("[TB] FAIL sw_response: got lat=%0d err=%b data=%h expected lat=2 err=0 data=0", lat, e, d);
    end
    assertions_evaluated++;
    if (wr_cycles !== 1 || en_cycles !== 1 || last_wr_addr !== 32'd2 || last_wr_din !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL sw_bus: got wr=%0d en=%0d addr=%h din=%h expected 1 1 2 deadbeef",
               wr_cycles, en_cycles, last_wr_addr, last_wr_din);
    end
    assertions_evaluated++;
    if (av !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sw_pulse_width: got rsp_valid=%b after RSP expected 0", av);
    end
    send(1'b0, 3'b010, 32'h8, 32'h0, lat, d, e, av, hd);
    assertions_evaluated++;
    if (lat !== 3 || d !== 32'hDEADBEEF || e !== 1'b0 || last_rd_addr !== 32'd2) begin
      failures++;
      $display("[TB] FAIL lw_response: got lat=%0d data=%h err=%b rd_addr=%h expected 3 deadbeef 0 2",
               lat, d, e, last_rd_addr);
    end
    f3s[0] = 3'b000; addrs[0] = 32'hB; exps[0] = 32'hFFFFFFDE;
    f3s[1] = 3'b100; addrs[1] = 32'hB; exps[1] = 32'h000000DE;
    f3s[2] = 3'b001; addrs[2] = 32'hA; exps[2] = 32'hFFFFDEAD;
    f3s[3] = 3'b101; addrs[3] = 32'h8; exps[3] = 32'h0000BEEF;
    for (int i = 0; i < 4; i++) begin
      send(1'b0, f3s[i], addrs[i], 32'h0, lat, d, e, av, hd);
      assertions_evaluated++;
      if (lat !== 3 || d !== exps[i] || e !== 1'b0) begin
        failures++;
        $display("[TB] FAIL subword_load_%0d: got lat=%0d data=%h err=%b expected 3 %h 0", i, lat, d, e, exps[i]);
      end
    end
    send(1'b1, 3'b000, 32'h9, 32'hFFFFFF12, lat, d, e, av, hd);
    assertions_evaluated++;
    if (lat !== 4 || e !== 1'b0 || wr_cycles !== 1 || en_cycles !== 2 || last_wr_din !== 32'hDEAD12EF || last_wr_addr !== 32'd2) begin
      failures++;
      $display("[TB] FAIL sb_rmw: got lat=%0d err=%b wr=%0d en=%0d din=%h addr=%h expected 4 0 1 2 dead12ef 2",
               lat, e, wr_cycles, en_cycles, last_wr_din, last_wr_addr);
    end
    send(1'b1, 3'b001, 32'hA, 32'hABCD5678, lat, d, e, av, hd);
    assertions_evaluated++;
    if (lat !== 4 || e !== 1'b0 || last_wr_din !== 32'h567812EF) begin
      failures++;
      $display("[TB] FAIL sh_rmw: got lat=%0d err=%b din=%h expected 4 0 567812ef", lat, e, last_wr_din);
    end
    ref_mem[2] = 32'h567812EF;
    send(1'b0, 3'b010, 32'h8, 32'h0, lat, d, e, av, hd);
    assertions_evaluated++;
    if (d !== 32'h567812EF) begin
      failures++;
      $display("[TB] FAIL rmw_readback: got %h expected 567812ef", d);
    end
  endtask

  task automatic test_errors();
    int lat;
    logic [31:0] d, hd;
    logic e, av;
    logic we_t [4];
    logic [2:0] f3_t [4];
    logic [31:0] addr_t [4];
    we_t[0] = 1'b0; f3_t[0] = 3'b010; addr_t[0] = 32'h6;
    we_t[1] = 1'b0; f3_t[1] = 3'b001; addr_t[1] = 32'h5;
    we_t[2] = 1'b0; f3_t[2] = 3'b011; addr_t[2] = 32'h10;
    we_t[3] = 1'b1; f3_t[3] = 3'b100; addr_t[3] = 32'h10;
    for (int i = 0; i < 4; i++) begin
      send(we_t[i], f3_t[i], addr_t[i], 32'h12345678, lat, d, e, av, hd);
      assertions_evaluated++;
      if (lat !== 1 || e !== 1'b1 || d !== 32'h0 || en_cycles !== 0) begin
        failures++;
        $display("[TB] FAIL error_case_%0d: got lat=%0d err=%b data=%h en=%0d expected 1 1 0 0", i, lat, e, d, en_cycles);
      end
      assertions_evaluated++;
      if (hd !== 32'h0 || av !== 1'b0) begin
        failures++;
        $display("[TB] FAIL error_hold_%0d: got held=%h valid_after=%b expected 0 0", i, hd, av);
      end
    end
  endtask

  task automatic test_range();
    int lat;
    logic [31:0] d, hd;
    logic e, av;
    send(1'b0, 3'b010, 32'h54, 32'h0, lat, d, e, av, hd);
`ifdef LSU_RANGE_CHECK_EN
    assertions_evaluated++;
    if (lat !== 1 || e !== 1'b1 || d !== 32'h0 || en_cycles !== 0) begin
      failures++;
      $display("[TB] FAIL range_reject: got lat=%0d err=%b data=%h en=%0d expected 1 1 0 0", lat, e, d, en_cycles);
    end
`else
    assertions_evaluated++;
    if (lat !== 3 || e !== 1'b0 || last_rd_addr !== 32'd21 || d !== ref_mem[21]) begin
      failures++;
      $display("[TB] FAIL range_forward: got lat=%0d err=%b rd_addr=%h data=%h expected 3 0 15 %h",
               lat, e, last_rd_addr, d, ref_mem[21]);
    end
`endif
  endtask

  task automatic test_random();
    int lat, exp_lat, exp_en;
    logic [31:0] d, hd, addr, wd, exp_data, exp_word;
    logic e, av, we, exp_e;
    logic [2:0] f3;
    int idx;
    for (int n = 0; n < 150; n++) begin
      idx = $urandom_range(0, MEM_WORDS - 1);
      addr = 32'(idx * 4 + $urandom_range(0, 3));
      f3 = 3'($urandom_range(0, 7));
      we = 1'($urandom);
      wd = $urandom;
      exp_e = ref_err(we, f3, addr);
      exp_lat = ref_latency(we, f3, addr);
      exp_data = (exp_e || we) ? 32'h0 : ref_load(ref_mem[idx], f3, addr);
      exp_word = ref_merge(ref_mem[idx], f3, addr, wd);
      exp_en = exp_e ? 0 : (exp_lat == 2 ? 1 : (exp_lat == 3 ? 1 : 2));
      send(we, f3, addr, wd, lat, d, e, av, hd);
      assertions_evaluated++;
      if (lat !== exp_lat || e !== exp_e || d !== exp_data) begin
        failures++;
        $display("[TB] FAIL random_rsp_%0d: we=%b f3=%0d addr=%h got lat=%0d err=%b data=%h expected %0d %b %h",
                 n, we, f3, addr, lat, e, d, exp_lat, exp_e, exp_data);
      end
      assertions_evaluated++;
      if (en_cycles !== exp_en || av !== 1'b0 || hd !== exp_data) begin
        failures++;
        $display("[TB] FAIL random_bus_%0d: got en=%0d valid_after=%b held=%h expected %0d 0 %h",
                 n, en_cycles, av, hd, exp_en, exp_data);
      end
      if (we && !exp_e) begin
        assertions_evaluated++;
        if (wr_cycles !== 1 || last_wr_din !== exp_word || last_wr_addr !== 32'(idx)) begin
          failures++;
          $display("[TB] FAIL random_store_%0d: got wr=%0d din=%h addr=%h expected 1 %h %h",
                   n, wr_cycles, last_wr_din, last_wr_addr, exp_word, idx);
        end
        ref_mem[idx] = exp_word;
      end
    end
    for (int i = 0; i < MEM_WORDS; i++) begin
      assertions_evaluated++;
      if (mem[i] !== ref_mem[i]) begin
        failures++;
        $display("[TB] FAIL random_mem_word_%0d: got %h expected %h", i, mem[i], ref_mem[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic r_we [8];
    logic [2:0] r_f3 [8];
    logic [31:0] r_addr [8];
    logic [31:0] r_wd [8];
    logic [31:0] exp_data [8];
    logic exp_err [8];
    int exp_lat [8];
    int idx, guard;
    logic seen;
    for (int i = 0; i < 8; i++) begin
      idx = $urandom_range(0, MEM_WORDS - 1);
      r_we[i] = 1'($urandom);
      r_f3[i] = 3'($urandom_range(0, 5));
      r_addr[i] = 32'(idx * 4 + 2 * $urandom_range(0, 1));
      r_wd[i] = $urandom;
      exp_err[i] = ref_err(r_we[i], r_f3[i], r_addr[i]);
      exp_lat[i] = ref_latency(r_we[i], r_f3[i], r_addr[i]);
      exp_data[i] = (exp_err[i] || r_we[i]) ? 32'h0 : ref_load(ref_mem[idx], r_f3[i], r_addr[i]);
      if (r_we[i] && !exp_err[i]) ref_mem[idx] = ref_merge(ref_mem[idx], r_f3[i], r_addr[i], r_wd[i]);
    end
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        bus.req_valid = 1'b1;
        bus.req_we = r_we[i];
        bus.req_funct3 = r_f3[i];
        bus.req_addr = r_addr[i];
        bus.req_wdata = r_wd[i];
      end else begin
        bus.req_valid = 1'b0;
      end
      guard = 0;
      seen = (i == 0);
      while (1) begin
        @(negedge CLK);
        guard++;
        if (i > 0 && bus.rsp_valid === 1'b1) begin
          seen = 1'b1;
          assertions_evaluated++;
          if (bus.rsp_err !== exp_err[i-1] || bus.rsp_data !== exp_data[i-1]) begin
            failures++;
            $display("[TB] FAIL b2b_rsp_%0d: got err=%b data=%h expected %b %h",
                     i - 1, bus.rsp_err, bus.rsp_data, exp_err[i-1], exp_data[i-1]);
          end
        end
        if (bus.req_ready === 1'b1 || guard > 20) break;
      end
      if (i > 0) begin
        assertions_evaluated++;
        if (guard !== exp_lat[i-1] + 1 || !seen) begin
          failures++;
          $display("[TB] FAIL b2b_gap_%0d: got %0d cycles to ready (rsp seen=%b) expected %0d",
                   i - 1, guard, seen, exp_lat[i-1] + 1);
        end
      end
      if (i < 8) begin
        @(posedge CLK);
        #1;
      end
    end
    for (int i = 0; i < MEM_WORDS; i++) begin
      assertions_evaluated++;
      if (mem[i] !== ref_mem[i]) begin
        failures++;
        $display("[TB] FAIL b2b_mem_word_%0d: got %h expected %h", i, mem[i], ref_mem[i]);
      end
    end
  endtask

  initial begin
    RST_N = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    clear_monitor();
    test_reset();
    test_directed();
    test_errors();
    test_range();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions_evaluated, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached before the test sequence finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
